// File: rtl/mult_div_unit_pkg.sv
// Shared CPU definitions for the HI/LO multiply-divide unit.
// Holds the op encoding (also used by the decoder and ID/EX stage), the FSM
// state encoding and a helper that classifies multi-cycle ops.
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    OpNone  = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMthi  = 4'd5,
    OpMtlo  = 4'd6
  } mdu_op_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } mdu_state_e;

  // True for ops that occupy the unit for several cycles.
  function automatic logic is_long_op(input logic [3:0] op);
    return (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
  endfunction

  // True for the two divide ops.
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit.
// A start pulse with MULT/MULTU/DIV/DIVU latches the operands and holds busy
// for MULT_CYCLES or DIV_CYCLES cycles; the registered result lands in hi/lo
// on the final edge. MTHI/MTLO write hi/lo directly while idle.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous, active-high reset
//   start  - one-cycle launch pulse for multi-cycle ops
//   op     - operation code (mdu_op_e)
//   src_a  - rs operand (dividend / multiplicand / MTHI-MTLO data)
//   src_b  - rt operand (divisor / multiplier)
//   busy   - high while an operation is in flight
//   hi, lo - architectural HI / LO registers
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  mdu_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;

  // Products: sign-extending to 64 bits makes the low 64 bits of an unsigned
  // multiply equal the signed product.
  logic [63:0] prod_s, prod_u;
  // Division is done on magnitudes so INT_MIN / -1 wraps to INT_MIN cleanly.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};

    a_neg  = (op_q == OpDiv) && a_q[31];
    b_neg  = (op_q == OpDiv) && b_q[31];
    a_mag  = a_neg ? (~a_q + 32'd1) : a_q;
    b_mag  = b_neg ? (~b_q + 32'd1) : b_q;
    // Divide-by-zero results are discarded; avoid a zero divisor anyway.
    b_safe = (b_q == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quo    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem    = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      StIdle: begin
        if (start && is_long_op(op)) begin
          state_d = StBusy;
          op_d    = op;
          a_d     = src_a;
          b_d     = src_b;
          cnt_d   = is_div_op(op) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
        end else if (op == OpMthi) begin
          hi_d = src_a;
        end else if (op == OpMtlo) begin
          lo_d = src_a;
        end
      end
      StBusy: begin
        if (cnt_q <= CntW'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
          if (op_q == OpMult) begin
            {hi_d, lo_d} = prod_s;
          end else if (op_q == OpMultu) begin
            {hi_d, lo_d} = prod_u;
          end else if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpNone;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == StBusy);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a table of multi-cycle ops with
// hand-computed results, then directed sequences for MTHI/MTLO, ignored
// requests while busy, reset abort, back-to-back ops and reset priority.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .src_a(src_a),
    .src_b(src_b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Entered and left on a falling edge; returns at the first busy cycle.
  task automatic launch(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    @(negedge clk);
    start = 1'b0;
    op    = OpNone;
    // Operand changes after launch must not matter.
    src_a = 32'hDEADBEEF;
    src_b = 32'hCAFEF00D;
  endtask

  // Counts busy cycles from the current falling edge, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic move_to(input logic [3:0] o, input logic [31:0] v);
    op    = o;
    src_a = v;
    @(negedge clk);
    op    = OpNone;
    src_a = 32'd0;
  endtask

  initial begin
    int          cyc;
    logic [31:0] prev_hi, prev_lo;

    vecs[0]  = '{OpMult,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{OpMultu, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2]  = '{OpDiv,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{OpDivu,  32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4]  = '{OpDiv,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5]  = '{OpMult,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
    vecs[6]  = '{OpDivu,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
    vecs[7]  = '{OpDiv,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[8]  = '{OpMult,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};
    vecs[9]  = '{OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[10] = '{OpDiv,   32'd5,        32'd0,        32'hFFFFFFFE, 32'h00000001, 10};

    clk   = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    op    = OpNone;
    src_a = '0;
    src_b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    prev_hi = 32'd0;
    prev_lo = 32'd0;
    for (int i = 0; i < 11; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_hold_hi", i), hi, prev_hi);
      check($sformatf("v%0d_hold_lo", i), lo, prev_lo);
      wait_done(cyc);
      check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].cycles));
      check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      prev_hi = vecs[i].hi;
      prev_lo = vecs[i].lo;
    end

    // MTHI / MTLO in idle write on the next edge without busy.
    move_to(OpMthi, 32'h12345678);
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_lo", lo, 32'h00000001);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    move_to(OpMtlo, 32'hA5A5A5A5);
    check("mtlo_lo", lo, 32'hA5A5A5A5);
    check("mtlo_hi", hi, 32'h12345678);

    // MTHI and a fresh start while busy are ignored.
    launch(OpMult, 32'd2, 32'd3);
    op    = OpMthi;
    src_a = 32'h0BADF00D;
    @(negedge clk);
    check("busy_mthi_hi", hi, 32'h12345678);
    check("busy_mthi_busy", {31'd0, busy}, 32'd1);
    start = 1'b1;
    op    = OpDivu;
    src_a = 32'd9;
    src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    op    = OpNone;
    wait_done(cyc);
    check("busy_ign_cycles", 32'(cyc + 2), 32'd5);
    check("busy_ign_hi", hi, 32'd0);
    check("busy_ign_lo", lo, 32'd6);
    @(negedge clk);
    check("busy_ign_no_relaunch", {31'd0, busy}, 32'd0);

    // Reset on the 4th busy cycle of a DIV aborts it.
    move_to(OpMthi, 32'h55555555);
    move_to(OpMtlo, 32'h66666666);
    launch(OpDiv, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (15) @(negedge clk);
    check("abort_late_hi", hi, 32'd0);
    check("abort_late_lo", lo, 32'd0);
    check("abort_late_busy", {31'd0, busy}, 32'd0);

    // Back-to-back: DIVU launched in the first idle cycle after a MULT.
    launch(OpMult, 32'd6, 32'd7);
    wait_done(cyc);
    check("b2b_mult_cycles", 32'(cyc), 32'd5);
    check("b2b_mult_hi", hi, 32'd0);
    check("b2b_mult_lo", lo, 32'd42);
    launch(OpDivu, 32'd100, 32'd7);
    check("b2b_one_gap", {31'd0, busy}, 32'd1);
    wait_done(cyc);
    check("b2b_div_cycles", 32'(cyc), 32'd10);
    check("b2b_div_hi", hi, 32'd2);
    check("b2b_div_lo", lo, 32'd14);

    // Reset wins over a simultaneous start.
    reset = 1'b1;
    start = 1'b1;
    op    = OpMult;
    src_a = 32'd3;
    src_b = 32'd3;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    op    = OpNone;
    check("rst_prio_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("rst_prio_busy2", {31'd0, busy}, 32'd0);
    check("rst_prio_lo", lo, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 MULT_CYCLES, 5, busy duration in cycles for MULT/MULTU.
REQ-002 DIV_CYCLES, 10, busy duration in cycles for DIV/DIVU.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse launching MULT/MULTU/DIV/DIVU held in op.
REQ-006 op  input  4  operation code: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 src_a  input  32  forwarded rs operand (dividend / multiplicand / MTHI-MTLO data).
REQ-008 src_b  input  32  forwarded rt operand (divisor / multiplier).
REQ-009 busy  output  1  high while an operation is in flight.
REQ-010 hi  output  32  architectural HI register.
REQ-011 lo  output  32  architectural LO register.

Function
REQ-012 The unit SHALL be a two-state FSM: IDLE, BUSY; busy SHALL equal (state == BUSY), registered.
REQ-013 In IDLE, start with op in {MULT, MULTU, DIV, DIVU} SHALL latch src_a, src_b and op, load the counter with MULT_CYCLES or DIV_CYCLES, and enter BUSY at that edge.
REQ-014 busy SHALL rise the cycle after start and stay high for exactly MULT_CYCLES / DIV_CYCLES cycles.
REQ-015 In BUSY the counter SHALL decrement each cycle; on the cycle it reaches 1, the edge SHALL write hi/lo and return to IDLE.
REQ-016 MULT: {hi,lo} = signed 64-bit src_a*src_b; MULTU: unsigned 64-bit product.
REQ-017 DIV: lo = signed quotient truncated toward zero, hi = remainder with sign of dividend; DIVU: unsigned quotient/remainder.
REQ-018 DIV with 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-019 DIV/DIVU with src_b == 0 SHALL run full DIV_CYCLES and leave hi/lo unchanged.
REQ-020 hi/lo SHALL NOT change during BUSY before completion; reads during BUSY return old values.
REQ-021 MTHI/MTLO in IDLE SHALL write src_a to hi/lo at the next edge, no busy; start is not required for them.
REQ-022 MTHI/MTLO or any start arriving while BUSY SHALL be ignored (upstream stalls on start|busy).
REQ-023 op NONE, or start with op in {NONE, MTHI, MTLO}, SHALL cause no FSM transition.
REQ-024 Operands latched at start SHALL be used; src_a/src_b changes during BUSY SHALL have no effect.

Reset
REQ-025 reset SHALL force state IDLE, counter 0, busy 0, hi 0, lo 0, latched operands 0 at the next edge.
REQ-026 reset during BUSY SHALL abort the operation; no hi/lo write occurs afterward.
REQ-027 reset SHALL take priority over start, MTHI/MTLO and completion in the same cycle.

Structure
REQ-028 op encoding constants and FSM state encoding SHALL live in the shared CPU definitions package used by the decoder and ID/EX stage.
REQ-029 No sub-module; product/quotient computed combinationally from latched operands, result registered at completion.
REQ-030 Counter width SHALL fit max(MULT_CYCLES, DIV_CYCLES).

Verification
REQ-031 MULT start, src_a=0xFFFFFFFE(-2), src_b=3 -> busy high cycles 1..5, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy 0.
REQ-032 MULTU start, src_a=0xFFFFFFFF, src_b=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
REQ-033 DIV start, src_a=-7, src_b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> busy 10 cycles, hi/lo unchanged.
REQ-034 MTHI src_a=0x12345678 during BUSY -> ignored; same in IDLE -> hi=0x12345678 next edge, busy stays 0.
REQ-035 DIV start, reset asserted on 4th busy cycle -> next edge busy=0, hi=lo=0, no later update.
REQ-036 Back-to-back: MULT completes, start DIV in first IDLE cycle -> busy low exactly one cycle between operations, both results correct.
